// File: rtl/vga_mem_port_arb.sv
// vga_mem_port_arb
// ----------------
// Port-A controller for the dual-port VGA frame memory (port B belongs to
// the scan-out reader). Two requesters share port A under round-robin
// arbitration: requester 0 is game logic and requester 1 is the
// debug/loader path. A screen-clear engine can take exclusive ownership
// of port A and fill addresses 0..CLEAR_WORDS-1 with a constant.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   rN_req/we/addr/wdata    requester N access (held until granted)
//   rN_gnt                  access performed this cycle (combinational)
//   rN_rvalid               read data valid on rdata (one cycle after grant)
//   rdata                   read data, wired straight from mem_q
//   clear_start/value       start a clear / fill value
//   clear_busy, clear_done  clear engine owns port A / end-of-clear pulse
//   mem_addr/data/we, mem_q memory port A
module vga_mem_port_arb #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int CLEAR_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clear_start,
  input  logic [DATA_WIDTH-1:0] clear_value,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  // One extra counter bit so a clear of the full 2**ADDR_WIDTH space
  // still reaches its terminal count without wrapping.
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(CLEAR_WORDS - 1);

  state_t                state_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  last_gnt_q, last_gnt_d;
  logic                  r0_rvalid_q, r0_rvalid_d;
  logic                  r1_rvalid_q, r1_rvalid_d;
  logic                  done_q;
  logic                  grant_ok, pick0, pick1;

  always_comb begin
    // Grants are suppressed while in reset or while the clear engine runs.
    grant_ok = rst_n && (state_q == IDLE);
    // last_gnt_q holds the index of the most recent winner; on a tie the
    // other requester wins.
    pick0    = r0_req && (!r1_req || last_gnt_q);
    pick1    = r1_req && !pick0;
    r0_gnt   = grant_ok && pick0;
    r1_gnt   = grant_ok && pick1;

    mem_we   = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    if (state_q == CLEAR) begin
      mem_we   = rst_n;
      mem_addr = cnt_q[ADDR_WIDTH-1:0];
      mem_data = value_q;
    end else if (r0_gnt) begin
      mem_we   = r0_we;
      mem_addr = r0_addr;
      mem_data = r0_wdata;
    end else if (r1_gnt) begin
      mem_we   = r1_we;
      mem_addr = r1_addr;
      mem_data = r1_wdata;
    end

    last_gnt_d = last_gnt_q;
    if (r0_gnt)      last_gnt_d = 1'b0;
    else if (r1_gnt) last_gnt_d = 1'b1;

    r0_rvalid_d = r0_gnt && !r0_we;
    r1_rvalid_d = r1_gnt && !r1_we;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      value_q     <= '0;
      last_gnt_q  <= 1'b1;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          // A grant in this same cycle still completes; the clear starts next.
          if (clear_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            value_q <= clear_value;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign r0_rvalid  = r0_rvalid_q;
  assign r1_rvalid  = r1_rvalid_q;
  assign rdata      = mem_q;
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = done_q;

endmodule

// File: tb/tb_vga_mem_port_arb.sv
module tb_vga_mem_port_arb;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] rdata;
  logic          clear_start;
  logic [DW-1:0] clear_value;
  logic          clear_busy, clear_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_we;
  logic [DW-1:0] mem_q;

  int vec  = 0;
  int errs = 0;

  logic [DW-1:0] mem [256];
  logic          loaded = 1'b0;

  always #5 clk = ~clk;

  // Frame memory port A model: registered q_a, write-through forwarding.
  // Preloaded with mem[i] = i on the first edge.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_data;
      mem_q         <= mem_data;
    end else begin
      mem_q <= mem[mem_addr];
    end
  end

  vga_mem_port_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_WORDS(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata),
    .clear_start(clear_start), .clear_value(clear_value),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  task automatic test_reset;
    rst_n = 1'b0; r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b0; r1_we = 1'b0;
    r0_addr = 8'd5; r1_addr = 8'd9; r0_wdata = '0; r1_wdata = '0;
    clear_start = 1'b0; clear_value = '0;
    repeat (2) @(negedge clk);
    #1;
    vec++; if (r0_gnt !== 1'b0) begin errs++; $display("FAIL rst_r0_gnt got %b want 0", r0_gnt); end
    vec++; if (r1_gnt !== 1'b0) begin errs++; $display("FAIL rst_r1_gnt got %b want 0", r1_gnt); end
    vec++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    vec++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin errs++; $display("FAIL rst_rvalid got %b%b want 00", r0_rvalid, r1_rvalid); end
    vec++; if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin errs++; $display("FAIL rst_clear got busy=%b done=%b want 0 0", clear_busy, clear_done); end
    @(negedge clk); rst_n = 1'b1; #1;
    vec++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin errs++; $display("FAIL rst_first_tie got %b%b want 10", r0_gnt, r1_gnt); end
  endtask

  // Entered while r0 holds the first grant after reset; r1 is due next.
  task automatic test_round_robin;
    logic nxt1;
    nxt1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      vec++; if (r0_gnt !== !nxt1 || r1_gnt !== nxt1) begin errs++; $display("FAIL rr_gnt[%0d] got %b%b want %b%b", k, r0_gnt, r1_gnt, !nxt1, nxt1); end
      vec++; if (mem_addr !== (nxt1 ? 8'd9 : 8'd5)) begin errs++; $display("FAIL rr_addr[%0d] got %0d want %0d", k, mem_addr, nxt1 ? 9 : 5); end
      vec++; if (r0_rvalid !== nxt1 || r1_rvalid !== !nxt1 || rdata !== (nxt1 ? 8'd5 : 8'd9)) begin
        errs++; $display("FAIL rr_rvalid[%0d] got %b%b/%0d want %b%b/%0d", k, r0_rvalid, r1_rvalid, rdata, nxt1, !nxt1, nxt1 ? 5 : 9);
      end
      nxt1 = !nxt1;
    end
    @(negedge clk); r0_req = 1'b0; r1_req = 1'b0; #1;
    vec++; if (r0_rvalid !== 1'b1 || rdata !== 8'd5) begin errs++; $display("FAIL rr_last_rvalid got %b/%0d want 1/5", r0_rvalid, rdata); end
    vec++; if (mem_we !== 1'b0 || mem_addr !== 8'd0) begin errs++; $display("FAIL rr_nogrant got we=%b addr=%0d want 0 0", mem_we, mem_addr); end
  endtask

  task automatic test_write_readback;
    @(negedge clk); r1_req = 1'b1; r1_we = 1'b1; r1_addr = 8'd3; r1_wdata = 8'hA5; #1;
    vec++; if (r1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd3 || mem_data !== 8'hA5) begin
      errs++; $display("FAIL wr_grant got gnt=%b we=%b addr=%0d data=%h want 1 1 3 a5", r1_gnt, mem_we, mem_addr, mem_data);
    end
    @(negedge clk); r1_we = 1'b0; #1;
    vec++; if (r1_gnt !== 1'b1 || mem_we !== 1'b0) begin errs++; $display("FAIL rd_grant got gnt=%b we=%b want 1 0", r1_gnt, mem_we); end
    vec++; if (r1_rvalid !== 1'b0) begin errs++; $display("FAIL wr_no_rvalid got %b want 0", r1_rvalid); end
    @(negedge clk); r1_req = 1'b0; #1;
    vec++; if (r1_rvalid !== 1'b1 || rdata !== 8'hA5) begin errs++; $display("FAIL readback got %b/%h want 1/a5", r1_rvalid, rdata); end
  endtask

  task automatic test_clear;
    @(negedge clk); clear_start = 1'b1; clear_value = 8'h0F; r0_req = 1'b1; r0_we = 1'b0; r0_addr = 8'd20; #1;
    vec++; if (r0_gnt !== 1'b1 || clear_busy !== 1'b0) begin errs++; $display("FAIL clr_accept got gnt=%b busy=%b want 1 0", r0_gnt, clear_busy); end
    @(negedge clk); clear_start = 1'b0;
    for (int i = 0; i < CW; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      vec++; if (mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_data !== 8'h0F) begin
        errs++; $display("FAIL clr_write[%0d] got we=%b addr=%0d data=%h want 1 %0d 0f", i, mem_we, mem_addr, mem_data, i);
      end
      vec++; if (r0_gnt !== 1'b0 || clear_busy !== 1'b1 || clear_done !== 1'b0) begin
        errs++; $display("FAIL clr_own[%0d] got gnt=%b busy=%b done=%b want 0 1 0", i, r0_gnt, clear_busy, clear_done);
      end
      if (i == 0) begin
        vec++; if (r0_rvalid !== 1'b1 || rdata !== 8'd20) begin errs++; $display("FAIL clr_pre_read got %b/%0d want 1/20", r0_rvalid, rdata); end
      end
    end
    @(negedge clk); #1;
    vec++; if (clear_done !== 1'b1 || clear_busy !== 1'b0) begin errs++; $display("FAIL clr_done got done=%b busy=%b want 1 0", clear_done, clear_busy); end
    vec++; if (r0_gnt !== 1'b1 || mem_addr !== 8'd20) begin errs++; $display("FAIL clr_done_gnt got gnt=%b addr=%0d want 1 20", r0_gnt, mem_addr); end
    @(negedge clk); r0_req = 1'b0; #1;
    vec++; if (clear_done !== 1'b0) begin errs++; $display("FAIL clr_done_pulse got %b want 0", clear_done); end
    for (int i = 0; i <= CW; i++) begin
      vec++; if (mem[i] !== ((i < CW) ? 8'h0F : DW'(i))) begin errs++; $display("FAIL clr_mem[%0d] got %h want %h", i, mem[i], (i < CW) ? 8'h0F : DW'(i)); end
    end
  endtask

  task automatic test_start_collision;
    @(negedge clk); clear_start = 1'b1; clear_value = 8'h3C;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 8'd2; r0_wdata = 8'h77; #1;
    vec++; if (r0_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'd2 || mem_data !== 8'h77) begin
      errs++; $display("FAIL col_grant got gnt=%b we=%b addr=%0d data=%h want 1 1 2 77", r0_gnt, mem_we, mem_addr, mem_data);
    end
    @(negedge clk); clear_start = 1'b0; r0_req = 1'b0; r0_we = 1'b0;
    for (int i = 0; i < CW; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 5) clear_start = 1'b1;
      if (i == 6) clear_start = 1'b0;
      #1;
      if (i == 0) begin
        vec++; if (mem[2] !== 8'h77) begin errs++; $display("FAIL col_first_write got %h want 77", mem[2]); end
      end
      vec++; if (mem_addr !== AW'(i) || mem_data !== 8'h3C || clear_busy !== 1'b1) begin
        errs++; $display("FAIL col_clr[%0d] got addr=%0d data=%h busy=%b want %0d 3c 1", i, mem_addr, mem_data, clear_busy, i);
      end
    end
    @(negedge clk); #1;
    vec++; if (clear_done !== 1'b1) begin errs++; $display("FAIL col_done got %b want 1", clear_done); end
    @(negedge clk); #1;
    vec++; if (clear_busy !== 1'b0 || clear_done !== 1'b0 || mem_we !== 1'b0) begin
      errs++; $display("FAIL col_no_restart got busy=%b done=%b we=%b want 0 0 0", clear_busy, clear_done, mem_we);
    end
    vec++; if (mem[2] !== 8'h3C) begin errs++; $display("FAIL col_overwrite got %h want 3c", mem[2]); end
  endtask

  task automatic test_reset_mid_clear;
    @(negedge clk); clear_start = 1'b1; clear_value = 8'hE1; #1;
    @(negedge clk); clear_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      vec++; if (mem_we !== 1'b1 || mem_addr !== AW'(i)) begin errs++; $display("FAIL rmc_write[%0d] got we=%b addr=%0d want 1 %0d", i, mem_we, mem_addr, i); end
    end
    @(negedge clk); rst_n = 1'b0; #1;
    vec++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rmc_we_in_reset got %b want 0", mem_we); end
    @(negedge clk); rst_n = 1'b1; #1;
    vec++; if (clear_busy !== 1'b0 || clear_done !== 1'b0 || mem_we !== 1'b0) begin
      errs++; $display("FAIL rmc_abort got busy=%b done=%b we=%b want 0 0 0", clear_busy, clear_done, mem_we);
    end
    @(negedge clk); #1;
    vec++; if (clear_done !== 1'b0) begin errs++; $display("FAIL rmc_no_done got %b want 0", clear_done); end
    for (int i = 0; i < CW; i++) begin
      vec++; if (mem[i] !== ((i < 7) ? 8'hE1 : 8'h3C)) begin errs++; $display("FAIL rmc_mem[%0d] got %h want %h", i, mem[i], (i < 7) ? 8'hE1 : 8'h3C); end
    end
    // After reset requester 0 wins the first tie, then requester 1.
    @(negedge clk); r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b0; r1_we = 1'b0; #1;
    vec++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin errs++; $display("FAIL rmc_tie0 got %b%b want 10", r0_gnt, r1_gnt); end
    @(negedge clk); #1;
    vec++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b1) begin errs++; $display("FAIL rmc_tie1 got %b%b want 01", r0_gnt, r1_gnt); end
    @(negedge clk); r0_req = 1'b0; r1_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_write_readback;
    test_clear;
    test_start_collision;
    test_reset_mid_clear;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
